// File: rtl/priority_mux_pkg.sv
// Shared definitions for the priority-mux req/ack protocol: requester FSM
// states and the priority-value convention (lower value wins).
package priority_mux_pkg;

  // Requester handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Lower numeric value means higher priority; this is the value that wins.
  localparam int PRIO_HIGHEST = 0;

  // Lowest-urgency priority representable in a field of the given width.
  function automatic int min_priority(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full/empty come from the MSB
// comparison and level is the modular pointer difference.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; both pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read after being written.
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/priority_req_source.sv
// Requester endpoint for one priority-mux input: buffers tagged words, presents
// the head word with a request, and promotes its priority while it waits.
module priority_req_source
  import priority_mux_pkg::*;
#(
  parameter int N_PRIORITY_WIDTH = 2,
  parameter int N_SIGNAL_WIDTH   = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int AGE_LIMIT        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [N_SIGNAL_WIDTH-1:0]     wr_data,
  input  logic [N_PRIORITY_WIDTH-1:0]   wr_priority,
  output logic [N_SIGNAL_WIDTH-1:0]     signal_data,
  output logic [N_PRIORITY_WIDTH-1:0]   signal_priority,
  output logic                          signal_req,
  input  logic                          signal_ack,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          protocol_err
);

  localparam int FW    = N_PRIORITY_WIDTH + N_SIGNAL_WIDTH;
  localparam int AGE_W = $clog2(AGE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT - 1);
  localparam logic [N_PRIORITY_WIDTH-1:0] PRIO_LOWEST =
    N_PRIORITY_WIDTH'(min_priority(N_PRIORITY_WIDTH));
  localparam logic [N_PRIORITY_WIDTH-1:0] PRIO_TOP = N_PRIORITY_WIDTH'(PRIO_HIGHEST);

  state_t            state;
  state_t            state_next;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_rdata;
  logic [AGE_W-1:0]  age_cnt;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (pop),
    .wdata ({wr_priority, wr_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign wr_ready = !fifo_full;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE waits for a word, REQ waits for ack, HOLD lasts one cycle.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_next = REQ;
      REQ:     if (signal_ack)  state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: request only in REQ, pop the head only from IDLE.
  always_comb begin
    signal_req = (state == REQ);
    pop        = (state == IDLE) && !fifo_empty;
  end

  // Output register, aging counter and sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      signal_data     <= '0;
      signal_priority <= PRIO_LOWEST;
      age_cnt         <= '0;
      protocol_err    <= 1'b0;
    end else begin
      if (signal_ack && state != REQ) protocol_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pop) begin
            {signal_priority, signal_data} <= fifo_rdata;
            age_cnt                        <= '0;
          end
        end
        REQ: begin
          // Ack wins over promotion: the granted word keeps its priority.
          if (signal_ack) begin
            age_cnt <= '0;
          end else if (age_cnt == AGE_MAX) begin
            if (signal_priority != PRIO_TOP) begin
              signal_priority <= signal_priority - 1'b1;
              age_cnt         <= '0;
            end
          end else begin
            age_cnt <= age_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_req_source.sv
// Bench for priority_req_source: directed stimulus, grants checked by a
// scoreboard monitor, state/level checks inline.
module tb_priority_req_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic [1:0] wr_priority;
  logic [7:0] signal_data;
  logic [1:0] signal_priority;
  logic       signal_req;
  logic       signal_ack;
  logic [2:0] level;
  logic       protocol_err;

  typedef struct {
    logic [7:0] data;
    logic [1:0] prio;
  } grant_t;

  grant_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  priority_req_source #(
    .N_PRIORITY_WIDTH (2),
    .N_SIGNAL_WIDTH   (8),
    .FIFO_DEPTH       (4),
    .AGE_LIMIT        (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_data         (wr_data),
    .wr_priority     (wr_priority),
    .signal_data     (signal_data),
    .signal_priority (signal_priority),
    .signal_req      (signal_req),
    .signal_ack      (signal_ack),
    .level           (level),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [7:0] d, input logic [1:0] p);
    wr_valid    = 1'b1;
    wr_data     = d;
    wr_priority = p;
    step(1);
    wr_valid    = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!signal_req && n < 20) begin
      step(1);
      n++;
    end
    check("req_timeout", 32'(signal_req), 32'd1);
  endtask

  // Queue the expected grant, pulse ack for one cycle.
  task automatic grant(input logic [7:0] d, input logic [1:0] p);
    exp_q.push_back('{data: d, prio: p});
    signal_ack = 1'b1;
    step(1);
    signal_ack = 1'b0;
  endtask

  // Scoreboard monitor: every granted word must match the queue head.
  always @(negedge clk) begin
    if (!rst && signal_req && signal_ack) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_grant", 32'd1, 32'd0);
      end else begin
        grant_t e;
        e = exp_q.pop_front();
        check("sb_data", 32'(signal_data), 32'(e.data));
        check("sb_prio", 32'(signal_priority), 32'(e.prio));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_priority = '0; signal_ack = 1'b0;
    step(2);
    check("rst_level",    32'(level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_req",      32'(signal_req), 32'd0);
    check("rst_data",     32'(signal_data), 32'd0);
    check("rst_prio",     32'(signal_priority), 32'd3);
    check("rst_err",      32'(protocol_err), 32'd0);
    rst = 1'b0;

    // Single word: level=1 after the write edge, request one edge later.
    write_word(8'hA5, 2'd2);
    check("t1_level_after_wr", 32'(level), 32'd1);
    check("t1_req_before_pop", 32'(signal_req), 32'd0);
    step(1);
    check("t1_level_after_pop", 32'(level), 32'd0);
    check("t1_req",  32'(signal_req), 32'd1);
    check("t1_data", 32'(signal_data), 32'hA5);
    check("t1_prio", 32'(signal_priority), 32'd2);
    grant(8'hA5, 2'd2);
    check("t1_hold_req",  32'(signal_req), 32'd0);
    check("t1_hold_data", 32'(signal_data), 32'hA5);
    step(1);
    check("t1_idle_req", 32'(signal_req), 32'd0);
    step(2);
    check("t1_stays_idle", 32'(signal_req), 32'd0);

    // Fill: first word moves to the output register, the rest fill the FIFO.
    for (int i = 1; i <= 4; i++) write_word(8'(i), 2'd1);
    check("t2_level3",   32'(level), 32'd3);
    check("t2_req",      32'(signal_req), 32'd1);
    check("t2_head",     32'(signal_data), 32'h01);
    check("t2_ready_l3", 32'(wr_ready), 32'd1);
    write_word(8'h05, 2'd1);
    check("t2_level4",   32'(level), 32'd4);
    check("t2_full",     32'(wr_ready), 32'd0);
    write_word(8'h06, 2'd1);
    check("t2_refused",  32'(level), 32'd4);
    for (int i = 1; i <= 5; i++) begin
      wait_req();
      check("t2_drain_data", 32'(signal_data), 32'(i));
      grant(8'(i), 2'd1);
    end
    step(3);
    check("t2_level0",   32'(level), 32'd0);
    check("t2_idle",     32'(signal_req), 32'd0);
    check("t2_ready",    32'(wr_ready), 32'd1);

    // Aging: 16 cycles per promotion step, saturating at 0.
    write_word(8'h3C, 2'd3);
    step(1);
    check("t3_p3_start", 32'(signal_priority), 32'd3);
    step(15);
    check("t3_p3_end",   32'(signal_priority), 32'd3);
    step(1);
    check("t3_p2_start", 32'(signal_priority), 32'd2);
    step(15);
    check("t3_p2_end",   32'(signal_priority), 32'd2);
    step(1);
    check("t3_p1",       32'(signal_priority), 32'd1);
    step(16);
    check("t3_p0",       32'(signal_priority), 32'd0);
    step(40);
    check("t3_p0_sat",   32'(signal_priority), 32'd0);
    check("t3_data",     32'(signal_data), 32'h3C);
    check("t3_req",      32'(signal_req), 32'd1);
    grant(8'h3C, 2'd0);
    step(2);

    // Ack on the cycle the age counter is at its limit: no promotion.
    write_word(8'h77, 2'd2);
    step(1);
    check("t4_req",  32'(signal_req), 32'd1);
    step(15);
    check("t4_prio_pre", 32'(signal_priority), 32'd2);
    grant(8'h77, 2'd2);
    check("t4_hold_req",  32'(signal_req), 32'd0);
    check("t4_hold_prio", 32'(signal_priority), 32'd2);
    check("t4_hold_data", 32'(signal_data), 32'h77);
    step(1);
    check("t4_idle_prio", 32'(signal_priority), 32'd2);

    // Stray ack while idle and empty: sticky error, FIFO untouched.
    signal_ack = 1'b1;
    step(1);
    signal_ack = 1'b0;
    check("t5_err",     32'(protocol_err), 32'd1);
    check("t5_level",   32'(level), 32'd0);
    check("t5_req",     32'(signal_req), 32'd0);
    step(3);
    check("t5_err_sticky", 32'(protocol_err), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t5_err_clr", 32'(protocol_err), 32'd0);

    // Reset in the middle of a request with two words buffered.
    write_word(8'h11, 2'd0);
    write_word(8'h22, 2'd0);
    write_word(8'h33, 2'd0);
    check("t6_level2", 32'(level), 32'd2);
    check("t6_req",    32'(signal_req), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_req0",   32'(signal_req), 32'd0);
    check("t6_level0", 32'(level), 32'd0);
    check("t6_prio",   32'(signal_priority), 32'd3);
    check("t6_ready",  32'(wr_ready), 32'd1);
    check("t6_data",   32'(signal_data), 32'd0);
    step(3);
    check("t6_stay_idle", 32'(signal_req), 32'd0);

    check("sb_pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
